// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one VRAM controller port among NCORES datapath cores. Arbitration is
// round-robin. Each core keeps the same active/w/addr/in request and ready/out
// response handshake it would use with a private VRAM. Only one request is
// outstanding at the memory at any time, and every output is registered.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   core_active  per-core request valid, held until that core's ready pulse
//   core_w       per-core write(1)/read(0)
//   core_addr    per-core address, core i in [i*ADDR_W +: ADDR_W]
//   core_in      per-core write data, same packing as core_addr
//   core_ready   one-cycle completion pulse, one-hot or zero
//   core_out     read data broadcast to all cores, valid with core_ready
//   mem_active   request to the VRAM controller
//   mem_w        write enable to the VRAM controller
//   mem_addr     address to the VRAM controller
//   mem_in       write data to the VRAM controller
//   mem_out      read data from the VRAM controller, valid with mem_ready
//   mem_ready    one-cycle completion pulse from the VRAM controller
//   arb_err      sticky watchdog timeout flag
//   grant_id     index of the currently granted core (debug)
//
// Configuration
//   VRAM_ARB_TIMEOUT_EN  When defined, a watchdog aborts a request that sees no
//                        mem_ready within TIMEOUT_CYCLES busy cycles. The
//                        aborted request still completes toward the core, with
//                        core_out=0, and arb_err is set until the next rst.
//                        When undefined, the arbiter waits for mem_ready
//                        indefinitely and arb_err is tied to 0.
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int NCORES         = 4,
    parameter int ADDR_W         = 19,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int GID_W         = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        core_active,
    input  logic [NCORES-1:0]        core_w,
    input  logic [NCORES*ADDR_W-1:0] core_addr,
    input  logic [NCORES*DATA_W-1:0] core_in,
    output logic [NCORES-1:0]        core_ready,
    output logic [DATA_W-1:0]        core_out,
    output logic                     mem_active,
    output logic                     mem_w,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_in,
    input  logic [DATA_W-1:0]        mem_out,
    input  logic                     mem_ready,
    output logic                     arb_err,
    output logic [GID_W-1:0]         grant_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Round-robin pick: the first active core scanning last+1, last+2, ...
    // modulo NCORES. The result is {found, index}.
    function automatic logic [GID_W:0] rr_pick(input logic [NCORES-1:0] act,
                                               input logic [GID_W-1:0]  last);
        logic             found_v;
        logic [GID_W-1:0] idx_v;
        logic [GID_W-1:0] cand_v;
        found_v = 1'b0;
        idx_v   = {GID_W{1'b0}};
        for (int k = 1; k <= NCORES; k++) begin
            cand_v = GID_W'((int'(last) + k) % NCORES);
            if (!found_v && act[cand_v]) begin
                found_v = 1'b1;
                idx_v   = cand_v;
            end else begin
                found_v = found_v;
            end
        end
        return {found_v, idx_v};
    endfunction

    state_t             state_r, state_nxt_s;
    logic               mem_active_r, mem_active_nxt_s;
    logic               mem_w_r, mem_w_nxt_s;
    logic [ADDR_W-1:0]  mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0]  mem_in_r, mem_in_nxt_s;
    logic [NCORES-1:0]  core_ready_r, core_ready_nxt_s;
    logic [DATA_W-1:0]  core_out_r, core_out_nxt_s;
    logic [GID_W-1:0]   grant_id_r, grant_id_nxt_s;
    logic [GID_W-1:0]   last_grant_r, last_grant_nxt_s;
    logic               pick_found_s;
    logic [GID_W-1:0]   pick_idx_s;
    logic [NCORES-1:0]  grant_onehot_s;
    logic [ADDR_W-1:0]  addr_arr_s [NCORES];
    logic [DATA_W-1:0]  data_arr_s [NCORES];

`ifdef VRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
    logic               arb_err_r, arb_err_nxt_s;
`endif

    // Unpack the flat per-core request buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            addr_arr_s[i] = core_addr[i*ADDR_W +: ADDR_W];
            data_arr_s[i] = core_in[i*DATA_W +: DATA_W];
        end
    end

    // Arbitration decision and the ready pulse vector for the current grant.
    always_comb begin
        {pick_found_s, pick_idx_s} = rr_pick(core_active, last_grant_r);
        grant_onehot_s = {{(NCORES-1){1'b0}}, 1'b1} << grant_id_r;
    end

    // Next-state and next-output logic. Every output is registered from these values.
    always_comb begin
        state_nxt_s      = state_r;
        mem_active_nxt_s = mem_active_r;
        mem_w_nxt_s      = mem_w_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_in_nxt_s     = mem_in_r;
        core_ready_nxt_s = {NCORES{1'b0}};
        core_out_nxt_s   = core_out_r;
        grant_id_nxt_s   = grant_id_r;
        last_grant_nxt_s = last_grant_r;
`ifdef VRAM_ARB_TIMEOUT_EN
        tmo_cnt_nxt_s    = tmo_cnt_r;
        arb_err_nxt_s    = arb_err_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (pick_found_s) begin
                    mem_active_nxt_s = 1'b1;
                    mem_w_nxt_s      = core_w[pick_idx_s];
                    mem_addr_nxt_s   = addr_arr_s[pick_idx_s];
                    mem_in_nxt_s     = data_arr_s[pick_idx_s];
                    grant_id_nxt_s   = pick_idx_s;
                    last_grant_nxt_s = pick_idx_s;
                    state_nxt_s      = S_BUSY;
`ifdef VRAM_ARB_TIMEOUT_EN
                    tmo_cnt_nxt_s    = {CNT_W{1'b0}};
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                // The mem_* registers keep their latched values. Request inputs are ignored here.
                if (mem_ready) begin
                    mem_active_nxt_s = 1'b0;
                    core_ready_nxt_s = grant_onehot_s;
                    state_nxt_s      = S_DONE;
                    if (!mem_w_r) begin
                        core_out_nxt_s = mem_out;
                    end else begin
                        core_out_nxt_s = core_out_r;
                    end
                end
`ifdef VRAM_ARB_TIMEOUT_EN
                // This is the last allowed busy cycle, and mem_ready has not arrived.
                else if (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_active_nxt_s = 1'b0;
                    arb_err_nxt_s    = 1'b1;
                    core_ready_nxt_s = grant_onehot_s;
                    core_out_nxt_s   = {DATA_W{1'b0}};
                    state_nxt_s      = S_DONE;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1);
                    state_nxt_s   = S_BUSY;
                end
`else
                else begin
                    state_nxt_s = S_BUSY;
                end
`endif
            end
            S_DONE: begin
                // Single ready cycle. The requester drops core_active here, before the next scan.
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s      = S_IDLE;
                mem_active_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            mem_active_r <= 1'b0;
            mem_w_r      <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_in_r     <= {DATA_W{1'b0}};
            core_ready_r <= {NCORES{1'b0}};
            core_out_r   <= {DATA_W{1'b0}};
            grant_id_r   <= {GID_W{1'b0}};
            last_grant_r <= GID_W'(NCORES - 1);
`ifdef VRAM_ARB_TIMEOUT_EN
            tmo_cnt_r    <= {CNT_W{1'b0}};
            arb_err_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            mem_active_r <= mem_active_nxt_s;
            mem_w_r      <= mem_w_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_in_r     <= mem_in_nxt_s;
            core_ready_r <= core_ready_nxt_s;
            core_out_r   <= core_out_nxt_s;
            grant_id_r   <= grant_id_nxt_s;
            last_grant_r <= last_grant_nxt_s;
`ifdef VRAM_ARB_TIMEOUT_EN
            tmo_cnt_r    <= tmo_cnt_nxt_s;
            arb_err_r    <= arb_err_nxt_s;
`endif
        end
    end

    assign mem_active = mem_active_r;
    assign mem_w      = mem_w_r;
    assign mem_addr   = mem_addr_r;
    assign mem_in     = mem_in_r;
    assign core_ready = core_ready_r;
    assign core_out   = core_out_r;
    assign grant_id   = grant_id_r;
`ifdef VRAM_ARB_TIMEOUT_EN
    assign arb_err    = arb_err_r;
`else
    assign arb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with NCORES=4, ADDR_W=19 and DATA_W=8.
// A table of per-cycle inputs and expected registered outputs covers reset, a
// single read, a spurious mem_ready, a write with stalls and mid-busy input
// changes, a reset that aborts a busy transaction, and the first grant after
// reset. Hand-written sequences then cover contention and round-robin
// wrap-around. When VRAM_ARB_TIMEOUT_EN is defined, a further sequence checks
// the watchdog.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int NC = 4;
    localparam int AW = 19;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   core_active;
    logic [NC-1:0]   core_w;
    logic [NC*AW-1:0] core_addr;
    logic [NC*DW-1:0] core_in;
    logic [NC-1:0]   core_ready;
    logic [DW-1:0]   core_out;
    logic            mem_active;
    logic            mem_w;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_in;
    logic [DW-1:0]   mem_out;
    logic            mem_ready;
    logic            arb_err;
    logic [1:0]      grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .core_active(core_active), .core_w(core_w),
        .core_addr(core_addr), .core_in(core_in),
        .core_ready(core_ready), .core_out(core_out),
        .mem_active(mem_active), .mem_w(mem_w),
        .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_out(mem_out), .mem_ready(mem_ready),
        .arb_err(arb_err), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [NC-1:0]   act;
        logic [NC-1:0]   w;
        logic [NC*AW-1:0] addr;
        logic [NC*DW-1:0] din;
        logic [DW-1:0]   mout;
        logic            mrdy;
        logic            e_mact;
        logic            e_mw;
        logic [AW-1:0]   e_maddr;
        logic [DW-1:0]   e_min;
        logic [NC-1:0]   e_rdy;
        logic [DW-1:0]   e_out;
        logic [1:0]      e_gid;
    } vec_t;

    vec_t vq[$];

    // Core addresses and write data (core3 .. core0).
    logic [NC*AW-1:0] addrs_a = {19'h7FFFF, 19'h00067, 19'h01B80, 19'h000AA};
    logic [NC*AW-1:0] addrs_b = {19'h7FFFF, 19'h01234, 19'h01B80, 19'h000AA};
    logic [NC*DW-1:0] din_a   = {8'h00, 8'h05, 8'h3C, 8'h00};

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    task automatic add_row(input logic r, input logic [3:0] a, input logic [3:0] w,
                           input logic [NC*AW-1:0] ad, input logic [7:0] mo, input logic mr,
                           input logic ema, input logic emw, input logic [18:0] emad,
                           input logic [7:0] emin, input logic [3:0] erdy,
                           input logic [7:0] eout, input logic [1:0] egid);
        vec_t v;
        v.rst = r; v.act = a; v.w = w; v.addr = ad; v.din = din_a; v.mout = mo; v.mrdy = mr;
        v.e_mact = ema; v.e_mw = emw; v.e_maddr = emad; v.e_min = emin;
        v.e_rdy = erdy; v.e_out = eout; v.e_gid = egid;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; core_active = 4'b0000; core_w = 4'b0000;
        core_addr = addrs_a; core_in = din_a; mem_out = 8'h00; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_row;
        logic [63:0] act_row;
        logic [1:0]  order [4];
        bit          seen;

        // ---------------- vector table ----------------
        //       rst   act      w        addr     mout   mrdy   mact  mw    maddr       min    rdy      out    gid
        add_row(1'b1, 4'b0000, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b0, 1'b0, 19'h00000, 8'h00, 4'b0000, 8'h00, 2'd0);
        add_row(1'b1, 4'b0000, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b0, 1'b0, 19'h00000, 8'h00, 4'b0000, 8'h00, 2'd0);
        add_row(1'b0, 4'b0010, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b1, 1'b0, 19'h01B80, 8'h3C, 4'b0000, 8'h00, 2'd1);
        add_row(1'b0, 4'b0010, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b1, 1'b0, 19'h01B80, 8'h3C, 4'b0000, 8'h00, 2'd1);
        add_row(1'b0, 4'b0010, 4'b0000, addrs_a, 8'hBF, 1'b1,  1'b0, 1'b0, 19'h01B80, 8'h3C, 4'b0010, 8'hBF, 2'd1);
        add_row(1'b0, 4'b0000, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b0, 1'b0, 19'h01B80, 8'h3C, 4'b0000, 8'hBF, 2'd1);
        add_row(1'b0, 4'b0000, 4'b0000, addrs_a, 8'h11, 1'b1,  1'b0, 1'b0, 19'h01B80, 8'h3C, 4'b0000, 8'hBF, 2'd1);
        add_row(1'b0, 4'b0100, 4'b0100, addrs_a, 8'h00, 1'b0,  1'b1, 1'b1, 19'h00067, 8'h05, 4'b0000, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0101, 4'b0100, addrs_b, 8'h00, 1'b0,  1'b1, 1'b1, 19'h00067, 8'h05, 4'b0000, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0101, 4'b0100, addrs_b, 8'h00, 1'b0,  1'b1, 1'b1, 19'h00067, 8'h05, 4'b0000, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0101, 4'b0100, addrs_b, 8'h00, 1'b0,  1'b1, 1'b1, 19'h00067, 8'h05, 4'b0000, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0101, 4'b0100, addrs_b, 8'h00, 1'b0,  1'b1, 1'b1, 19'h00067, 8'h05, 4'b0000, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0101, 4'b0100, addrs_b, 8'hEE, 1'b1,  1'b0, 1'b1, 19'h00067, 8'h05, 4'b0100, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0001, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b0, 1'b1, 19'h00067, 8'h05, 4'b0000, 8'hBF, 2'd2);
        add_row(1'b0, 4'b0001, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b1, 1'b0, 19'h000AA, 8'h00, 4'b0000, 8'hBF, 2'd0);
        add_row(1'b1, 4'b0001, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b0, 1'b0, 19'h00000, 8'h00, 4'b0000, 8'h00, 2'd0);
        add_row(1'b0, 4'b1001, 4'b0000, addrs_a, 8'h00, 1'b0,  1'b1, 1'b0, 19'h000AA, 8'h00, 4'b0000, 8'h00, 2'd0);

        rst = 1'b1; core_active = 4'b0000; core_w = 4'b0000;
        core_addr = addrs_a; core_in = din_a; mem_out = 8'h00; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; core_active = vq[i].act; core_w = vq[i].w;
            core_addr = vq[i].addr; core_in = vq[i].din;
            mem_out = vq[i].mout; mem_ready = vq[i].mrdy;
            @(posedge clk);
            #1;
            exp_row = {20'd0, vq[i].e_mact, vq[i].e_mw, vq[i].e_maddr, vq[i].e_min,
                       vq[i].e_rdy, vq[i].e_out, vq[i].e_gid, 1'b0};
            act_row = {20'd0, mem_active, mem_w, mem_addr, mem_in,
                       core_ready, core_out, grant_id, arb_err};
            check($sformatf("row%0d", i), act_row, exp_row);
        end

        // ---------------- contention: cores 0,1,3 request continuously ----------------
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;
        do_reset();
        core_active = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (mem_active === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                n_checks++; n_fail++;
                $display("FAIL grant_wait%0d: got no mem_active expected grant to core %0d", t, order[t]);
            end else begin
                check($sformatf("grant%0d_id", t), {62'd0, grant_id}, {62'd0, order[t]});
                check($sformatf("grant%0d_addr", t), {45'd0, mem_addr},
                      {45'd0, core_addr[int'(order[t])*AW +: AW]});
                mem_out = 8'h40 + 8'(t); mem_ready = 1'b1;
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                check($sformatf("grant%0d_ready", t), {60'd0, core_ready},
                      {60'd0, 4'b0001 << order[t]});
                check($sformatf("grant%0d_out", t), {56'd0, core_out}, {56'd0, 8'h40 + 8'(t)});
            end
        end
        core_active = 4'b0000;
        @(posedge clk);
        #1;
        check("done_no_ready", {60'd0, core_ready}, 64'd0);

`ifdef VRAM_ARB_TIMEOUT_EN
        // ---------------- watchdog ----------------
        begin
            int cnt;
            do_reset();
            core_active = 4'b0001;
            @(posedge clk);
            #1;
            check("tmo_grant", {63'd0, mem_active}, 64'd1);
            cnt = 0;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(posedge clk);
                #1;
                cnt++;
                if (core_ready !== 4'b0000) seen = 1'b1;
            end
            check("tmo_latency", 64'(cnt), 64'd64);
            check("tmo_ready", {60'd0, core_ready}, 64'd1);
            check("tmo_out", {56'd0, core_out}, 64'd0);
            check("tmo_err", {63'd0, arb_err}, 64'd1);
            check("tmo_mact", {63'd0, mem_active}, 64'd0);
            core_active = 4'b0000;
            repeat (3) @(posedge clk);
            #1;
            check("tmo_err_sticky", {63'd0, arb_err}, 64'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("tmo_err_clear", {63'd0, arb_err}, 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
